// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: issues halfword fetches against a variable-latency memory
// and buffers {pc, instruction} pairs in a small queue handed to decode over valid/ready.
module if_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [15:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [15:0] imem_rsp_data,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        fetch_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_fetch_pc;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   r_occ;
    logic [PW-1:0]   r_q_head;
    logic [PW-1:0]   r_q_tail;
    logic [PW-1:0]   r_t_head;
    logic [PW-1:0]   r_t_tail;
    logic [15:0]     r_q_pc   [DEPTH];
    logic [15:0]     r_q_data [DEPTH];
    logic [15:0]     r_tag    [DEPTH];
    logic            r_err;

    logic            w_accept;
    logic            w_rsp_live;
    logic            w_rsp_orphan;
    logic            w_push;
    logic            w_pop;
    logic            w_credit;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_drop_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_accept     = imem_req_valid & imem_req_ready;
    assign w_rsp_live   = imem_rsp_valid & (r_out != '0);
    assign w_rsp_orphan = imem_rsp_valid & (r_out == '0);
    // A response landing in the redirect cycle belongs to the old stream and is discarded.
    assign w_push       = w_rsp_live & (r_drop == '0) & ~redirect_valid;
    assign w_pop        = ir_valid & ir_ready;
    assign w_credit     = ({1'b0, r_out} + {1'b0, r_occ}) < (CW + 1)'(DEPTH);
    assign w_out_nxt    = r_out + CW'(w_accept) - CW'(w_rsp_live);

    always_comb begin
        w_drop_nxt = r_drop;
        if (redirect_valid) begin
            w_drop_nxt = w_out_nxt;
        end else if (w_rsp_live && (r_drop != '0)) begin
            w_drop_nxt = r_drop - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req_valid = w_credit;
                if (redirect_valid && (w_out_nxt != '0)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drop_nxt == '0) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC & 16'hFFFE;
            r_out      <= '0;
            r_drop     <= '0;
            r_err      <= 1'b0;
            r_t_head   <= '0;
            r_t_tail   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_drop  <= w_drop_nxt;
            if (w_rsp_orphan) begin
                r_err <= 1'b1;
            end
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & 16'hFFFE;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 16'd2;
            end
            // Tags survive a redirect so stale responses still pop in order.
            if (w_accept) begin
                r_tag[r_t_tail] <= r_fetch_pc;
                r_t_tail        <= ptr_inc(r_t_tail);
            end
            if (w_rsp_live) begin
                r_t_head <= ptr_inc(r_t_head);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q_head <= '0;
            r_q_tail <= '0;
            r_occ    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_q_head <= '0;
            r_q_tail <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_q_pc[r_q_tail]   <= r_tag[r_t_head];
                r_q_data[r_q_tail] <= imem_rsp_data;
                r_q_tail           <= ptr_inc(r_q_tail);
            end
            if (w_pop) begin
                r_q_head <= ptr_inc(r_q_head);
            end
            r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

    assign imem_req_addr = r_fetch_pc;
    assign ir_valid      = (r_occ != '0);
    assign ir            = r_q_data[r_q_head];
    assign ir_pc         = r_q_pc[r_q_head];
    assign fetch_err     = r_err;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: fixed-latency memory models feed two instances,
// the second built with a wrapping RESET_PC.
module tb_if_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid;
    logic [15:0] req_addr, rsp_data;
    logic        ir_valid, ir_ready, fetch_err;
    logic [15:0] ir, ir_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    logic        req_valid2, rsp_valid2, ir_valid2, fetch_err2;
    logic [15:0] req_addr2, rsp_data2, ir2, ir_pc2;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          lat = 1;
    logic        inject = 1'b0;
    logic        pv [1:4];
    logic [15:0] pa [1:4];
    logic        m2_v = 1'b0;
    logic [15:0] m2_a = 16'h0;

    always #5 clock = ~clock;

    assign rsp_valid  = pv[lat] | inject;
    assign rsp_data   = pa[lat] ^ 16'h5A5A;
    assign rsp_valid2 = m2_v;
    assign rsp_data2  = m2_a ^ 16'h5A5A;

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) u_dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
    );

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFC)) u_dut2 (
        .clock(clock), .reset(reset),
        .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_req_addr(req_addr2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .ir_valid(ir_valid2), .ir_ready(1'b1), .ir(ir2), .ir_pc(ir_pc2),
        .redirect_valid(1'b0), .redirect_pc(16'h0000), .fetch_err(fetch_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int k = 1; k <= 4; k++) begin
            pv[k] = 1'b0;
            pa[k] = 16'h0;
        end
        m2_v = 1'b0;
        m2_a = 16'h0;
    endtask

    // One clock: sample handshakes mid-cycle, then advance the memory pipes after the edge.
    task automatic tick();
        logic        acc, acc2;
        logic [15:0] a, a2;
        @(negedge clock);
        acc  = req_valid & req_ready;
        a    = req_addr;
        acc2 = req_valid2;
        a2   = req_addr2;
        @(posedge clock);
        #1;
        if (acc) acc_cnt++;
        for (int k = 4; k >= 2; k--) begin
            pv[k] = pv[k-1];
            pa[k] = pa[k-1];
        end
        pv[1] = acc;
        pa[1] = a;
        m2_v  = acc2;
        m2_a  = a2;
        if (reset) clear_mem();
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        inject         = 1'b0;
        clear_mem();
        #1;
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_addr", {16'b0, req_addr}, 32'h0000);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("rst_ir", {16'b0, ir}, 32'h0000);
        chk("rst_ir_pc", {16'b0, ir_pc}, 32'h0000);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_addr2", {16'b0, req_addr2}, 32'hFFFC);
        tick();
        tick();
        reset   = 1'b0;
        acc_cnt = 0;
    endtask

    initial begin
        int n;
        // Streaming with zero-wait memory; second instance checks PC wrap.
        lat = 1; req_ready = 1'b1; ir_ready = 1'b1;
        do_reset();
        tick();
        chk("t1_req_valid", {31'b0, req_valid}, 32'd1);
        chk("t1_req_addr", {16'b0, req_addr}, 32'h0000);
        tick();
        chk("t1_no_ir_early", {31'b0, ir_valid}, 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t1_ir_valid", {31'b0, ir_valid}, 32'd1);
            chk("t1_ir_pc", {16'b0, ir_pc}, 32'(2 * i));
            chk("t1_ir", {16'b0, ir}, 32'(16'(2 * i) ^ 16'h5A5A));
            if (i < 3) chk("t4_ir_pc_wrap", {16'b0, ir_pc2}, 32'(16'(16'hFFFC + 2 * i)));
            tick();
        end

        // Decode stalled: credit caps requests at DEPTH.
        ir_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) tick();
        chk("t2_req_count", acc_cnt, 32'd4);
        chk("t2_req_valid_low", {31'b0, req_valid}, 32'd0);
        chk("t2_ir_valid", {31'b0, ir_valid}, 32'd1);
        chk("t2_ir_pc0", {16'b0, ir_pc}, 32'h0000);
        ir_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("t2_ir_pc", {16'b0, ir_pc}, 32'(2 * i));
        end

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3; req_ready = 1'b1; ir_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        req_ready = 1'b0;
        chk("t3_outstanding", acc_cnt, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        tick();
        redirect_valid = 1'b0;
        req_ready      = 1'b1;
        chk("t3_drain_req0", {31'b0, req_valid}, 32'd0);
        chk("t3_new_addr", {16'b0, req_addr}, 32'h0040);
        tick();
        chk("t3_drain_req1", {31'b0, req_valid}, 32'd0);
        chk("t3_drop_ir0", {31'b0, ir_valid}, 32'd0);
        tick();
        chk("t3_drop_ir1", {31'b0, ir_valid}, 32'd0);
        chk("t3_fetch_resume", {31'b0, req_valid}, 32'd1);
        n = 0;
        while (!ir_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t3_latency", n, 32'd4);
        chk("t3_ir_pc", {16'b0, ir_pc}, 32'h0040);
        chk("t3_ir", {16'b0, ir}, 32'h5A1A);

        // Memory back-pressure holds the address.
        lat = 1; req_ready = 1'b0; ir_ready = 1'b1;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_addr_hold", {16'b0, req_addr}, 32'h0000);
            chk("t5_req_valid", {31'b0, req_valid}, 32'd1);
        end
        chk("t5_no_accept", acc_cnt, 32'd0);
        req_ready = 1'b1;
        tick();
        chk("t5_addr_next", {16'b0, req_addr}, 32'h0002);
        chk("t5_one_accept", acc_cnt, 32'd1);
        tick();
        chk("t5_ir_pc0", {16'b0, ir_pc}, 32'h0000);
        tick();
        chk("t5_ir_pc1", {16'b0, ir_pc}, 32'h0002);

        // Orphan response sets the sticky error.
        req_ready = 1'b0;
        do_reset();
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("t6_err_set", {31'b0, fetch_err}, 32'd1);
        chk("t6_queue_empty", {31'b0, ir_valid}, 32'd0);
        tick();
        tick();
        chk("t6_err_sticky", {31'b0, fetch_err}, 32'd1);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
